mul_issue_sched: RTL and testbench
==================================

Name: mul_issue_sched

Overview:
- Round-robin scheduler sharing one fixed-latency pipelined 64x64 multiplier among N requesters.
- Accepts operand pairs over valid/ready, issues at most one pair per cycle, tracks requester IDs through a shadow pipeline and returns tagged 128-bit products through an output FIFO with backpressure.
- The multiplier cannot stall, so issue is credit-limited and a product is never dropped.
- Sits between the requester ports and the multiplier instance; the multiplier is external and connected via mul_x, mul_y and mul_prod.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2^IDW >= N.
- LATENCY, 5, cycles from operands on mul_x/mul_y to the matching product on mul_prod (>= 1).
- FIFO_DEPTH, 8, output FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N  per-requester operand valid.
- req_x  in  64*N  operand x; requester i at bits [64*i+63:64*i].
- req_y  in  64*N  operand y; same packing as req_x.
- req_ready  out  N  per-requester accept; at most one bit high per cycle.
- mul_x  out  64  operand x to the multiplier.
- mul_y  out  64  operand y to the multiplier.
- mul_prod  in  128  product from the multiplier.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  requester ID of the result.
- rsp_prod  out  128  unsigned product.
- busy  out  1  high while any operation is in flight or buffered.

Behaviour:
- Reset (synchronous, active-high):
  - Round-robin pointer = 0, shadow pipeline valid bits cleared, FIFO empty, credits = FIFO_DEPTH.
  - While reset is high: req_ready = 0, mul_x = mul_y = 0, rsp_valid = 0, busy = 0.
  - rsp_id and rsp_prod are don't-care while rsp_valid = 0.
- Credits:
  - credits counts free result slots (FIFO_DEPTH minus in-flight minus buffered).
  - Issue decrements credits; FIFO pop increments it; issue and pop in the same cycle leave it unchanged.
  - credits must never go below 0 or above FIFO_DEPTH.
- Arbitration (combinational per cycle):
  - Only when credits > 0, pick the first i with req_valid[i] = 1, searching from ptr upward modulo N.
  - req_ready[g] = 1 for the winner only; all others 0.
  - With credits = 0, all req_ready = 0 regardless of req_valid.
  - On issue (req_valid[g] & req_ready[g]), ptr <= (g+1) mod N; otherwise ptr holds.
  - req_ready may depend on req_valid. Requesters must hold their operands until accepted.
- Operand drive:
  - mul_x/mul_y = granted requester's req_x/req_y on an issue cycle; 0 otherwise.
  - These outputs are combinational; the multiplier registers them.
- Shadow pipeline:
  - LATENCY-stage shift register of {valid, id}.
  - Stage 0 is loaded with {issue, g} each cycle; the last stage's valid marks the cycle in which mul_prod holds that operation's product.
  - mul_prod is sampled only when the last-stage valid = 1; mul_prod in all other cycles is ignored.
- Output FIFO:
  - On last-stage valid, write {id, mul_prod} to the FIFO. Overflow is impossible by construction of the credits.
  - Output is first-word fall-through from registered storage: rsp_valid = !empty; rsp_id/rsp_prod show the head entry.
  - Pop when rsp_valid & rsp_ready.
  - Simultaneous write and pop is legal in any state, including empty and full.
  - A write into an empty FIFO becomes visible on rsp_valid the next cycle.
- Latency and throughput:
  - Issue in cycle t gives rsp_valid at t+LATENCY+1, provided the FIFO was otherwise empty.
  - Throughput is one issue per cycle while rsp_ready = 1.
- Ordering: results leave in issue order. Per requester, results arrive in that requester's issue order.
- Arithmetic: unsigned full 128-bit product; no truncation or rounding.
- busy = (credits != FIFO_DEPTH).
- Reset mid-operation: in-flight and buffered results are discarded. Products still emerging from the multiplier afterwards are ignored because the shadow valids are cleared. No rsp_valid occurs until new issues complete.

Test Plan:
- Single op: requester 1 sends x=3, y=5 at cycle t, rsp_ready=1 -> req_ready[1]=1 at t; rsp_valid at t+6 (LATENCY=5) with rsp_id=1, rsp_prod=15; busy=0 the cycle after the pop.
- Max operands: x=y=0xFFFF_FFFF_FFFF_FFFF -> rsp_prod=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. Also x=0 with y=max -> 0.
- Round robin: all four req_valid held high with distinct operands, rsp_ready=1 -> grants 0,1,2,3,0,1,...; one issue per cycle; rsp_id sequence identical to the issue order; every product correct.
- Backpressure: rsp_ready=0 with continuous requests -> exactly 8 issues, then req_ready all 0 and 8 results buffered. Raising rsp_ready for one cycle -> one pop and exactly one further issue. No result lost or duplicated.
- Boundary, credits=0: with the FIFO full, hold rsp_ready=1 for consecutive cycles -> pop and issue in the same cycle from the second cycle on; credits stays at 1 after the first pop; no overflow.
- Reset mid-op: issue 3 ops, assert reset for 1 cycle two cycles later -> rsp_valid stays 0 for at least LATENCY+2 cycles, busy=0, ptr=0. A subsequent request from requester 0 completes normally.

Source files
------------

// File: rtl/mul_issue_sched.sv
// Round-robin issue scheduler in front of a fixed-latency pipelined 64x64 multiplier.
// Issue is gated by result credits so the non-stallable multiplier can always retire into the FIFO.
module mul_issue_sched #(
   parameter int N          = 4,
   parameter int IDW        = 2,
   parameter int LATENCY    = 5,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req_valid,
   input  logic [64*N-1:0]      req_x,
   input  logic [64*N-1:0]      req_y,
   output logic [N-1:0]         req_ready,
   output logic [63:0]          mul_x,
   output logic [63:0]          mul_y,
   input  logic [127:0]         mul_prod,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [127:0]         rsp_prod,
   output logic                 busy
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   grant_id;
   logic [IDW-1:0]   idx;
   logic             found;
   logic             issue;
   logic             pop;
   logic             wr_en;
   logic [CW-1:0]    credits;

   logic [LATENCY-1:0] sh_valid;
   logic [IDW-1:0]     sh_id [LATENCY];

   logic [IDW-1:0]   mem_id   [FIFO_DEPTH];
   logic [127:0]     mem_prod [FIFO_DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;

   // Search from ptr upward, wrapping at N, for the first valid requester.
   always_comb begin
      found    = 1'b0;
      grant_id = '0;
      idx      = '0;
      for (int k = 0; k < N; k++) begin
         idx = IDW'((int'(ptr) + k) % N);
         if (!found && req_valid[idx]) begin
            found    = 1'b1;
            grant_id = idx;
         end
      end
   end

   assign issue = !reset && (credits != '0) && found;

   always_comb begin
      req_ready = '0;
      mul_x     = '0;
      mul_y     = '0;
      if (issue) begin
         req_ready[grant_id] = 1'b1;
         mul_x = req_x[64*int'(grant_id) +: 64];
         mul_y = req_y[64*int'(grant_id) +: 64];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (issue) begin
         ptr <= (int'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
      end
   end

   // Shadow of the multiplier pipeline: last stage lines up with mul_prod.
   always_ff @(posedge clk) begin
      if (reset) begin
         sh_valid <= '0;
      end else begin
         sh_valid[0] <= issue;
         for (int k = 1; k < LATENCY; k++) begin
            sh_valid[k] <= sh_valid[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      sh_id[0] <= grant_id;
      for (int k = 1; k < LATENCY; k++) begin
         sh_id[k] <= sh_id[k-1];
      end
   end

   assign wr_en = sh_valid[LATENCY-1];

   assign empty     = (wr_ptr == rd_ptr);
   assign rsp_valid = !reset && !empty;
   assign rsp_id    = mem_id[rd_ptr[AW-1:0]];
   assign rsp_prod  = mem_prod[rd_ptr[AW-1:0]];
   assign pop       = rsp_valid && rsp_ready;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_id[wr_ptr[AW-1:0]]   <= sh_id[LATENCY-1];
         mem_prod[wr_ptr[AW-1:0]] <= mul_prod;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Credits cover both in-flight and buffered results, so the FIFO cannot overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         credits <= CW'(FIFO_DEPTH);
      end else begin
         case ({issue, pop})
            2'b10:   credits <= credits - 1'b1;
            2'b01:   credits <= credits + 1'b1;
            default: credits <= credits;
         endcase
      end
   end

   assign busy = !reset && (credits != CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_mul_issue_sched.sv
// Directed bench for mul_issue_sched with a behavioural 5-stage multiplier attached.
module tb_mul_issue_sched;

   localparam int N   = 4;
   localparam int LAT = 5;
   localparam logic [63:0]  MAX64 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [127:0] MAXSQ = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;

   typedef struct packed {
      logic [1:0]   id;
      logic [127:0] prod;
   } rsp_t;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [64*N-1:0] req_x;
   logic [64*N-1:0] req_y;
   logic [N-1:0]    req_ready;
   logic [63:0]     mul_x;
   logic [63:0]     mul_y;
   logic [127:0]    mul_prod;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [1:0]      rsp_id;
   logic [127:0]    rsp_prod;
   logic            busy;

   logic [63:0] opx [N];
   logic [63:0] opy [N];
   rsp_t        exp_q [$];
   rsp_t        got_q [$];
   int          vectors = 0;
   int          miscompares = 0;

   logic [127:0] mpipe [LAT];

   mul_issue_sched #(.N(N), .IDW(2), .LATENCY(LAT), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
      .req_ready(req_ready), .mul_x(mul_x), .mul_y(mul_y), .mul_prod(mul_prod),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_prod(rsp_prod), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External multiplier: operands registered, product appears LAT cycles later.
   always @(posedge clk) begin
      mpipe[0] <= 128'(mul_x) * 128'(mul_y);
      for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
   end
   assign mul_prod = mpipe[LAT-1];

   task automatic pack();
      for (int i = 0; i < N; i++) begin
         req_x[64*i +: 64] = opx[i];
         req_y[64*i +: 64] = opy[i];
      end
   endtask

   // Advance one cycle, logging accepted operations and popped results.
   task automatic tick();
      logic [N-1:0] acc;
      acc = '0;
      #1;
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            exp_q.push_back(rsp_t'{id: 2'(i), prod: 128'(opx[i]) * 128'(opy[i])});
            acc[i] = 1'b1;
         end
      end
      if (rsp_valid && rsp_ready) got_q.push_back(rsp_t'{id: rsp_id, prod: rsp_prod});
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            opx[i] = opx[i] + 64'h0123_4567_89AB_CDEF;
            opy[i] = (opy[i] ^ 64'hF0F0_0F0F_3C3C_C3C3) + 64'(i + 1);
         end
      end
      pack();
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (rsp_valid) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         opx[i] = 64'hDEAD_BEEF_0000_0000 + 64'(i);
         opy[i] = 64'h1234_5678_9ABC_DEF0 + 64'(3 * i);
      end
      pack();
      repeat (3) @(posedge clk);
      #1;
      req_valid = 4'b1111;
      #1;
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      vectors++; if (mul_x !== 64'd0 || mul_y !== 64'd0) begin miscompares++; $display("FAIL reset_mul got=%h/%h exp=0", mul_x, mul_y); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL reset_ptr got=%b exp=0001", req_ready); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_single();
      bit ok;
      rsp_ready = 1'b1;
      opx[1] = 64'd3;
      opy[1] = 64'd5;
      pack();
      req_valid = 4'b0010;
      #1;
      vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL single_grant got=%b exp=0010", req_ready); end
      vectors++; if (mul_x !== 64'd3 || mul_y !== 64'd5) begin miscompares++; $display("FAIL single_mul got=%0d/%0d exp=3/5", mul_x, mul_y); end
      tick();
      req_valid = '0;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b exp=1", busy); end
      for (int k = 1; k <= 5; k++) begin
         vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_early t+%0d got=%b exp=0", k, rsp_valid); end
         tick();
      end
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL single_latency got=%b exp=1", rsp_valid); end
      vectors++; if (rsp_id !== 2'd1 || rsp_prod !== 128'd15) begin miscompares++; $display("FAIL single_result got=%0d/%0d exp=1/15", rsp_id, rsp_prod); end
      tick();
      vectors++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_idle busy=%b valid=%b exp=0/0", busy, rsp_valid); end
      wait_rsp(ok);
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_max_operands();
      bit ok;
      rsp_ready = 1'b1;
      opx[2] = MAX64;
      opy[2] = MAX64;
      pack();
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      wait_rsp(ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL max_timeout got=%b exp=1", ok); end
      vectors++; if (rsp_id !== 2'd2 || rsp_prod !== MAXSQ) begin miscompares++; $display("FAIL max_sq got=%0d/%h exp=2/%h", rsp_id, rsp_prod, MAXSQ); end
      tick();
      opx[3] = 64'd0;
      opy[3] = MAX64;
      pack();
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      wait_rsp(ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL zero_timeout got=%b exp=1", ok); end
      vectors++; if (rsp_id !== 2'd3 || rsp_prod !== 128'd0) begin miscompares++; $display("FAIL zero_prod got=%0d/%h exp=3/0", rsp_id, rsp_prod); end
      tick();
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_round_robin();
      logic [3:0] want;
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         want = 4'b0001 << (k % 4);
         vectors++; if (req_ready !== want) begin miscompares++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, want); end
         tick();
      end
      req_valid = '0;
      repeat (12) tick();
      vectors++; if (got_q.size() !== 8) begin miscompares++; $display("FAIL rr_count got=%0d exp=8", got_q.size()); end
      for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
         vectors++; if (got_q[j].id !== 2'(j % 4)) begin miscompares++; $display("FAIL rr_id%0d got=%0d exp=%0d", j, got_q[j].id, j % 4); end
         vectors++; if (got_q[j] !== exp_q[j]) begin miscompares++; $display("FAIL rr_prod%0d got=%h exp=%h", j, got_q[j].prod, exp_q[j].prod); end
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_backpressure();
      logic [3:0] want;
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      repeat (20) tick();
      vectors++; if (exp_q.size() !== 8) begin miscompares++; $display("FAIL bp_issues got=%0d exp=8", exp_q.size()); end
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_stall got=%b exp=0000", req_ready); end
      vectors++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL bp_buffered valid=%b busy=%b exp=1/1", rsp_valid, busy); end
      rsp_ready = 1'b1;
      #1;
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_pop_cycle got=%b exp=0000", req_ready); end
      tick();
      rsp_ready = 1'b0;
      #1;
      vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL bp_one_issue got=%b exp=0001", req_ready); end
      tick();
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_restall got=%b exp=0000", req_ready); end
      vectors++; if (exp_q.size() !== 9 || got_q.size() !== 1) begin miscompares++; $display("FAIL bp_counts got=%0d/%0d exp=9/1", exp_q.size(), got_q.size()); end
      // credits are now 0 with 7 buffered and 1 in flight
      rsp_ready = 1'b1;
      #1;
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL cr0_first got=%b exp=0000", req_ready); end
      tick();
      for (int k = 0; k < 4; k++) begin
         want = 4'b0001 << ((k + 1) % 4);
         vectors++; if (req_ready !== want || rsp_valid !== 1'b1) begin miscompares++; $display("FAIL cr0_issue_pop%0d got=%b/%b exp=%b/1", k, req_ready, rsp_valid, want); end
         tick();
      end
      req_valid = '0;
      repeat (30) tick();
      vectors++; if (got_q.size() !== 13 || exp_q.size() !== 13) begin miscompares++; $display("FAIL bp_total got=%0d/%0d exp=13/13", got_q.size(), exp_q.size()); end
      for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
         vectors++; if (got_q[j] !== exp_q[j]) begin miscompares++; $display("FAIL bp_result%0d got=%0d:%h exp=%0d:%h", j, got_q[j].id, got_q[j].prod, exp_q[j].id, exp_q[j].prod); end
      end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_drained busy=%b exp=0", busy); end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic test_reset_mid();
      bit ok;
      rsp_ready = 1'b1;
      req_valid = 4'b0111;
      repeat (3) tick();
      req_valid = '0;
      vectors++; if (exp_q.size() !== 3) begin miscompares++; $display("FAIL rmid_issued got=%0d exp=3", exp_q.size()); end
      repeat (2) tick();
      reset = 1'b1;
      #1;
      vectors++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_in_reset busy=%b valid=%b exp=0/0", busy, rsp_valid); end
      tick();
      reset = 1'b0;
      exp_q.delete();
      got_q.delete();
      for (int k = 0; k < LAT + 2; k++) begin
         #1;
         vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rmid_quiet%0d valid=%b busy=%b exp=0/0", k, rsp_valid, busy); end
         tick();
      end
      req_valid = 4'b1111;
      #1;
      vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rmid_ptr got=%b exp=0001", req_ready); end
      opx[0] = 64'd6;
      opy[0] = 64'd7;
      pack();
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      wait_rsp(ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rmid_timeout got=%b exp=1", ok); end
      vectors++; if (rsp_id !== 2'd0 || rsp_prod !== 128'd42) begin miscompares++; $display("FAIL rmid_result got=%0d/%0d exp=0/42", rsp_id, rsp_prod); end
      tick();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_idle busy=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_max_operands();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
